// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a multiplexed 7-segment display bus, debounces each
// digit's dwell, decodes the glyphs back to hex and reassembles whole frames.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | blank or illegal anode sample; stability counter held at 0
//   TRACK | one digit active; counting identical consecutive samples
//   HOLD  | digit accepted; waiting for the sample to change
module seg_scan_decoder #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DIGITS-1:0]     seg_an,
   input  logic [7:0]            seg,
   output logic [4*DIGITS-1:0]   frame_value,
   output logic [DIGITS-1:0]     frame_dp,
   output logic                  frame_done,
   output logic                  frame_valid,
   output logic                  seg_err,
   output logic                  an_err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIGITS-1:0]     s_an_q, p_an_q;
   logic [7:0]            s_seg_q, p_seg_q;
   logic [4*DIGITS-1:0]   work_val_q, frame_value_q, merged_val;
   logic [DIGITS-1:0]     work_dp_q, frame_dp_q, merged_dp;
   logic [DIGITS-1:0]     seen_q, seen_set;
   logic                  frame_done_q, frame_valid_q, seg_err_q, an_err_q;

   logic                  one_low, multi_low, active, illegal, same, accept;
   logic [IDX_W-1:0]      idx;
   logic                  glyph_ok;
   logic [3:0]            nib;

   // Glyph table lookup on the active-high gfedcba pattern.
   function automatic logic [4:0] decode(input logic [6:0] pat);
      case (pat)
         7'h3F: decode = {1'b1, 4'h0};
         7'h06: decode = {1'b1, 4'h1};
         7'h5B: decode = {1'b1, 4'h2};
         7'h4F: decode = {1'b1, 4'h3};
         7'h66: decode = {1'b1, 4'h4};
         7'h6D: decode = {1'b1, 4'h5};
         7'h7D: decode = {1'b1, 4'h6};
         7'h07: decode = {1'b1, 4'h7};
         7'h7F: decode = {1'b1, 4'h8};
         7'h6F: decode = {1'b1, 4'h9};
         7'h77: decode = {1'b1, 4'hA};
         7'h7C: decode = {1'b1, 4'hB};
         7'h39: decode = {1'b1, 4'hC};
         7'h5E: decode = {1'b1, 4'hD};
         7'h79: decode = {1'b1, 4'hE};
         7'h71: decode = {1'b1, 4'hF};
         default: decode = 5'b0_0000;
      endcase
   endfunction

   // Input sampling: current and previous registered samples. Anodes reset to
   // all-ones so the post-reset sample reads as blank, not as illegal.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_an_q  <= '1;
         p_an_q  <= '1;
         s_seg_q <= '1;
         p_seg_q <= '1;
      end else begin
         s_an_q  <= seg_an;
         p_an_q  <= s_an_q;
         s_seg_q <= seg;
         p_seg_q <= s_seg_q;
      end
   end

   // Anode classification: count low anodes and remember the index.
   always_comb begin
      one_low   = 1'b0;
      multi_low = 1'b0;
      idx       = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!s_an_q[k]) begin
            if (one_low) multi_low = 1'b1;
            one_low = 1'b1;
            idx     = IDX_W'(k);
         end
      end
      active        = one_low & ~multi_low;
      illegal       = multi_low;
      same          = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);
      {glyph_ok, nib} = decode(~s_seg_q[6:0]);
   end

   // FSM state and stability counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; accept fires on the edge where cnt reaches STABLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (active) begin
               state_d = TRACK;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         TRACK: begin
            if (!active) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (same) begin
               if (cnt_q < STABLE) cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == STABLE - CNT_W'(1)) begin
                  accept  = 1'b1;
                  state_d = HOLD;
               end
            end else begin
               cnt_d = CNT_W'(1);
            end
         end
         HOLD: begin
            if (!active) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same) begin
               state_d = TRACK;
               cnt_d   = CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Working frame with the digit being accepted merged in.
   always_comb begin
      merged_val             = work_val_q;
      merged_val[idx*4 +: 4] = nib;
      merged_dp              = work_dp_q;
      merged_dp[idx]         = ~s_seg_q[7];
      seen_set               = seen_q | (DIGITS'(1) << idx);
   end

   // Frame assembly, completion and sticky error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_val_q    <= '0;
         work_dp_q     <= '0;
         seen_q        <= '0;
         frame_value_q <= '0;
         frame_dp_q    <= '0;
         frame_done_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         seg_err_q     <= 1'b0;
         an_err_q      <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (illegal) an_err_q <= 1'b1;
         if (accept) begin
            if (glyph_ok) begin
               work_val_q <= merged_val;
               work_dp_q  <= merged_dp;
               if (&seen_set) begin
                  frame_value_q <= merged_val;
                  frame_dp_q    <= merged_dp;
                  frame_done_q  <= 1'b1;
                  frame_valid_q <= 1'b1;
                  seen_q        <= '0;
               end else begin
                  seen_q <= seen_set;
               end
            end else begin
               seg_err_q <= 1'b1;
            end
         end
      end
   end

   assign frame_value = frame_value_q;
   assign frame_dp    = frame_dp_q;
   assign frame_done  = frame_done_q;
   assign frame_valid = frame_valid_q;
   assign seg_err     = seg_err_q;
   assign an_err      = an_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans known frames onto the display bus
// and compares the reassembled outputs against hand-computed values.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  seg_an;
   logic [7:0]  seg;
   logic [31:0] frame_value;
   logic [7:0]  frame_dp;
   logic        frame_done, frame_valid, seg_err, an_err;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int base;
   int lat;

   logic [6:0] glyph_tab [0:15];

   seg_scan_decoder #(.DIGITS(8), .STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .seg_an      (seg_an),
      .seg         (seg),
      .frame_value (frame_value),
      .frame_dp    (frame_dp),
      .frame_done  (frame_done),
      .frame_valid (frame_valid),
      .seg_err     (seg_err),
      .an_err      (an_err)
   );

   always #5 clk = ~clk;

   // Count frame_done cycles away from the active edge.
   always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic [7:0] an, input logic [7:0] sg, input int n);
      seg_an = an;
      seg    = sg;
      repeat (n) @(negedge clk);
   endtask

   task automatic show(input int d, input logic [3:0] nib, input logic dpb, input int n);
      logic [7:0] an;
      an    = 8'hFF;
      an[d] = 1'b0;
      hold(an, ~{dpb, glyph_tab[nib]}, n);
   endtask

   task automatic scan(input logic [31:0] v, input logic [7:0] dp, input int lo, input int hi);
      for (int d = lo; d <= hi; d++) begin
         show(d, v[4*d +: 4], dp[d], 10);
         hold(8'hFF, 8'hFF, 1);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_value"}, frame_value, 32'h0);
      chk({tag, "_dp"},    {24'h0, frame_dp}, 32'h0);
      chk({tag, "_done"},  {31'h0, frame_done}, 32'h0);
      chk({tag, "_valid"}, {31'h0, frame_valid}, 32'h0);
      chk({tag, "_seg_err"}, {31'h0, seg_err}, 32'h0);
      chk({tag, "_an_err"},  {31'h0, an_err}, 32'h0);
   endtask

   initial begin
      glyph_tab[0]  = 7'h3F; glyph_tab[1]  = 7'h06; glyph_tab[2]  = 7'h5B; glyph_tab[3]  = 7'h4F;
      glyph_tab[4]  = 7'h66; glyph_tab[5]  = 7'h6D; glyph_tab[6]  = 7'h7D; glyph_tab[7]  = 7'h07;
      glyph_tab[8]  = 7'h7F; glyph_tab[9]  = 7'h6F; glyph_tab[10] = 7'h77; glyph_tab[11] = 7'h7C;
      glyph_tab[12] = 7'h39; glyph_tab[13] = 7'h5E; glyph_tab[14] = 7'h79; glyph_tab[15] = 7'h71;

      reset  = 1'b1;
      seg_an = 8'hFF;
      seg    = 8'hFF;
      repeat (3) @(negedge clk);
      chk_zero("in_reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("after_reset");

      // Basic frame
      base = done_cnt;
      scan(32'h12345678, 8'h00, 0, 7);
      hold(8'hFF, 8'hFF, 3);
      chk("f1_done_cnt", done_cnt - base, 1);
      chk("f1_value", frame_value, 32'h12345678);
      chk("f1_valid", {31'h0, frame_valid}, 1);
      chk("f1_seg_err", {31'h0, seg_err}, 0);
      chk("f1_an_err", {31'h0, an_err}, 0);

      // Continuous rescans with a decimal point on digit 3
      base = done_cnt;
      repeat (3) scan(32'hDEADBEEF, 8'h08, 0, 7);
      hold(8'hFF, 8'hFF, 3);
      chk("f2_done_cnt", done_cnt - base, 3);
      chk("f2_value", frame_value, 32'hDEADBEEF);
      chk("f2_dp", {24'h0, frame_dp}, 32'h08);

      // Accept latency and pulse width on the completing digit
      scan(32'h0F1E2D3C, 8'h00, 0, 6);
      seg_an = 8'h7F;
      seg    = ~{1'b0, glyph_tab[0]};
      lat    = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (frame_done) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, 5);
      @(negedge clk);
      chk("done_width", {31'h0, frame_done}, 0);
      hold(8'h7F, ~{1'b0, glyph_tab[0]}, 4);
      hold(8'hFF, 8'hFF, 2);
      chk("lat_value", frame_value, 32'h0F1E2D3C);
      chk("lat_dp", {24'h0, frame_dp}, 32'h0);

      // 3-sample glitch of glyph 8 on digit 2 after its real dwell
      base = done_cnt;
      scan(32'h13572468, 8'h00, 0, 2);
      show(2, 4'h8, 1'b0, 3);
      hold(8'hFF, 8'hFF, 1);
      scan(32'h13572468, 8'h00, 3, 7);
      hold(8'hFF, 8'hFF, 3);
      chk("glitch_done_cnt", done_cnt - base, 1);
      chk("glitch_value", frame_value, 32'h13572468);

      // Invalid glyph on digit 5
      base = done_cnt;
      scan(32'h87654321, 8'h00, 0, 4);
      hold(8'hDF, 8'hFF, 10);
      hold(8'hFF, 8'hFF, 1);
      scan(32'h87654321, 8'h00, 6, 7);
      hold(8'hFF, 8'hFF, 3);
      chk("segerr_flag", {31'h0, seg_err}, 1);
      chk("segerr_no_done", done_cnt - base, 0);
      chk("segerr_old_value", frame_value, 32'h13572468);
      scan(32'h87654321, 8'h00, 5, 5);
      hold(8'hFF, 8'hFF, 3);
      chk("segerr_done", done_cnt - base, 1);
      chk("segerr_value", frame_value, 32'h87654321);

      // Two anodes low
      base = done_cnt;
      hold(8'b11110011, ~{1'b0, glyph_tab[1]}, 6);
      hold(8'hFF, 8'hFF, 3);
      chk("anerr_flag", {31'h0, an_err}, 1);
      chk("anerr_no_done", done_cnt - base, 0);
      scan(32'hCAFEF00D, 8'h00, 0, 7);
      hold(8'hFF, 8'hFF, 3);
      chk("anerr_done", done_cnt - base, 1);
      chk("anerr_value", frame_value, 32'hCAFEF00D);
      chk("sticky_seg_err", {31'h0, seg_err}, 1);
      chk("sticky_an_err", {31'h0, an_err}, 1);

      // Reset mid-frame discards partial work
      scan(32'h11111111, 8'hFF, 0, 5);
      reset = 1'b1;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_zero("post_midreset");
      base = done_cnt;
      scan(32'h00000001, 8'h00, 6, 7);
      hold(8'hFF, 8'hFF, 3);
      chk("midreset_partial", done_cnt - base, 0);
      scan(32'h00000001, 8'h00, 0, 5);
      hold(8'hFF, 8'hFF, 3);
      chk("midreset_done", done_cnt - base, 1);
      chk("midreset_value", frame_value, 32'h00000001);
      chk("midreset_dp", {24'h0, frame_dp}, 32'h0);
      chk("midreset_valid", {31'h0, frame_valid}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment display interface (`seg_an`/`seg`) driven by the `single_cycle_MIPS` top level.
- Samples the scanned anode and segment lines, debounces each digit's dwell, and decodes the glyphs back to hex nibbles.
- Reassembles complete 8-digit frames into a 32-bit value.
- Used as an on-chip or bench-side monitor so the displayed value can be checked numerically instead of by eye.

Parameters:
- DIGITS, 8: number of scanned digits; `seg_an` width, frame width = 4*DIGITS.
- STABLE_CYCLES, 4: consecutive identical registered samples required to accept a digit (legal range 2..255).
- CNT_W, 8: width of the stability counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- seg_an  in  DIGITS  digit anodes, active-low; bit i selects digit i (digit 0 = least significant nibble).
- seg  in  8  segments, active-low; bit0=a … bit6=g, bit7=dp.
- frame_value  out  4*DIGITS  last completed frame, nibble i from digit i.
- frame_dp  out  DIGITS  decimal-point state per digit of the last frame, active-high.
- frame_done  out  1  one-cycle pulse when `frame_value` updates.
- frame_valid  out  1  high once at least one frame has completed.
- seg_err  out  1  sticky: a stable, non-hex glyph was seen.
- an_err  out  1  sticky: more than one anode was low in a registered sample.

Behaviour:
- Reset (async, active-high): every output is 0, internal registers are cleared, and the FSM enters IDLE.
- Input stage: `seg_an` and `seg` are registered once; all logic below works on the registered sample `s_an`/`s_seg`, and the previous sample is kept as `p_an`/`p_seg`.
- Sample classification:
  - Exactly one zero in `s_an` → active digit, index i.
  - All ones → blank.
  - Two or more zeros → illegal: set `an_err` and treat the sample as blank.
- Glyph decode: pat = ~`s_seg`[6:0], written gfedcba. Legal patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other pattern is invalid.
- FSM:
  - IDLE: blank or illegal sample; cnt=0. An active sample → TRACK with cnt=1.
  - TRACK: if (`s_an`,`s_seg`) equals (`p_an`,`p_seg`), cnt increments. When cnt reaches STABLE_CYCLES, the digit is accepted → HOLD. Any change → cnt=1 and stay in TRACK (or go to IDLE if blank).
  - HOLD: stay while the sample is unchanged, with no further accepts. Change to a different active sample → TRACK, cnt=1. Blank → IDLE.
- Accept (single cycle):
  - Valid glyph: work_val[4i+3:4i] <= nibble, work_dp[i] <= ~`s_seg`[7], seen[i] <= 1.
  - Invalid glyph: set `seg_err`, leave work/seen unchanged.
- Frame completion: on the accept that makes seen all ones (including that digit):
  - `frame_value` gets work_val with the new nibble merged; `frame_dp` is merged the same way.
  - `frame_done` = 1 for that one cycle; `frame_valid` = 1 and stays high.
  - seen clears in the same cycle.
- Re-acceptance:
  - Re-accepting an already-seen digit before the frame completes overwrites its nibble; seen is unchanged.
  - Frames need not arrive in scan order.
- Latency: from the first cycle the pins hold a new digit stably, accept occurs at clock edge 1+STABLE_CYCLES. `frame_done` asserts in the cycle after that edge.
- Glitches: any pin change shorter than STABLE_CYCLES samples never causes an accept.
- Counter saturation: cnt saturates at STABLE_CYCLES and never wraps.
- Sticky errors: `seg_err` and `an_err` clear only on reset.
- Reset mid-frame: partial work/seen are discarded; the next frame requires all DIGITS accepts.

Test Plan:
- Reset, then scan 0x12345678 (digit 0 → 7, each digit held 10 cycles, 1 blank cycle between digits) → exactly one `frame_done`, `frame_value`=0x12345678, `frame_valid`=1, both error flags 0.
- Continuous rescans of 0xDEADBEEF with dp on digit 3 only → one `frame_done` per full scan, `frame_value`=0xDEADBEEF, `frame_dp`=8'h08.
- During a scan, insert a 3-cycle glitch showing glyph 8 on digit 2 (STABLE_CYCLES=4) → glitch not accepted; frame equals the intended value.
- Hold digit 5 with pattern 7'h00 for 10 cycles → `seg_err`=1; no `frame_done` until digit 5 is rescanned with a legal glyph.
- Drive `seg_an`=8'b11110011 for 6 cycles → `an_err`=1, no accept; the subsequent full scan of 0xCAFEF00D completes normally.
- Accept digits 0–5 of a frame, pulse reset for 1 cycle → all outputs 0; then the full scan 0x00000001 → a single `frame_done` only after all 8 digits are accepted.
